// File: rtl/phasemean_multi.sv
// Multi-channel block mean of phase samples over 2^K enable-strobed vectors.
// Optional circular mode averages wrapped offsets from the window's first sample.
module phasemean_multi #(
  parameter int unsigned N_CH      = 6,
  parameter int unsigned W         = 16,
  parameter int unsigned KMAX      = 10,
  parameter int unsigned WRAP_MODE = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       enable,
  input  logic [$clog2(KMAX+1)-1:0]  K,
  input  logic [N_CH*W-1:0]          in_sampl,
  output logic [N_CH*W-1:0]          phaseout,
  output logic                       out_valid,
  output logic                       busy,
  output logic [KMAX:0]              sample_cnt
);

  localparam int unsigned KW = $clog2(KMAX + 1);
  localparam int unsigned AW = W + KMAX;

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  state_e                 state_q, state_d;
  logic [KW-1:0]          kw_q, kw_d, k_clamp;
  logic [KMAX:0]          cnt_q, cnt_d, win_len;
  logic signed [W-1:0]    ref_q [N_CH];
  logic signed [W-1:0]    ref_d [N_CH];
  logic signed [AW-1:0]   acc_q [N_CH];
  logic signed [AW-1:0]   acc_d [N_CH];
  logic [N_CH*W-1:0]      phase_q, phase_d, mean_vec;
  logic                   valid_q, valid_d;

  logic signed [W-1:0]    smp     [N_CH];
  logic signed [W-1:0]    diff    [N_CH];
  logic signed [AW-1:0]   contrib [N_CH];
  logic signed [AW:0]     sum_c   [N_CH];
  logic signed [AW:0]     shr_c   [N_CH];
  logic signed [AW:0]     rnd;
  logic [W-1:0]           mean_w  [N_CH];

  assign k_clamp = (K > KW'(KMAX)) ? KW'(KMAX) : K;
  assign win_len = (KMAX+1)'(1) << kw_q;

  // Per-channel datapath: increment to accumulate and rounded window mean.
  always_comb begin
    rnd = (kw_q == '0) ? '0 : (AW+1)'(1) << (kw_q - 1'b1);
    mean_vec = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      smp[c]  = in_sampl[c*W +: W];
      // W-bit difference wraps naturally through +/-pi.
      diff[c] = smp[c] - ref_q[c];
      contrib[c] = (WRAP_MODE != 0) ? AW'(diff[c]) : AW'(smp[c]);
      sum_c[c]  = (AW+1)'(acc_q[c]) + rnd;
      shr_c[c]  = sum_c[c] >>> kw_q;
      mean_w[c] = shr_c[c][W-1:0];
      mean_vec[c*W +: W] = (WRAP_MODE != 0) ? ref_q[c] + mean_w[c] : mean_w[c];
    end
  end

  always_comb begin
    state_d = state_q;
    kw_d    = kw_q;
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    acc_d   = acc_q;
    phase_d = phase_q;
    valid_d = 1'b0;

    // The completed window is reported even if clear arrives in DONE.
    if (state_q == StDone) begin
      valid_d = 1'b1;
      phase_d = mean_vec;
      state_d = StIdle;
      cnt_d   = '0;
    end

    if (clear) begin
      state_d = StIdle;
      cnt_d   = '0;
      for (int unsigned c = 0; c < N_CH; c++) acc_d[c] = '0;
    end else if (enable) begin
      if (state_q == StAcc) begin
        for (int unsigned c = 0; c < N_CH; c++) acc_d[c] = acc_q[c] + contrib[c];
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == win_len) state_d = StDone;
      end else begin
        // First sample of a window: from IDLE, or from DONE with no dead cycle.
        kw_d  = k_clamp;
        cnt_d = (KMAX+1)'(1);
        for (int unsigned c = 0; c < N_CH; c++) begin
          ref_d[c] = smp[c];
          acc_d[c] = (WRAP_MODE != 0) ? '0 : AW'(smp[c]);
        end
        state_d = (k_clamp == '0) ? StDone : StAcc;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      kw_q    <= '0;
      cnt_q   <= '0;
      ref_q   <= '{default: '0};
      acc_q   <= '{default: '0};
      phase_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kw_q    <= kw_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      acc_q   <= acc_d;
      phase_q <= phase_d;
      valid_q <= valid_d;
    end
  end

  assign phaseout   = phase_q;
  assign out_valid  = valid_q;
  assign busy       = (state_q == StAcc);
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_phasemean_multi.sv
// Scoreboard bench: circular and plain instances share stimulus; a window-level
// reference model predicts each mean and the cycle it must appear on.
module tb_phasemean_multi;

  localparam int unsigned N_CH = 6;
  localparam int unsigned W    = 16;
  localparam int unsigned KMAX = 10;
  localparam int unsigned KW   = 4;
  localparam int unsigned PW   = N_CH * W;

  typedef struct {
    logic [PW-1:0] v;
    int unsigned   c;
  } exp_t;

  logic            clock = 1'b0;
  logic            reset, clear, enable;
  logic [KW-1:0]   k;
  logic [PW-1:0]   in_sampl;
  logic [PW-1:0]   phase_o [2];
  logic            valid_o [2];
  logic            busy_o  [2];
  logic [KMAX:0]   cnt_o   [2];

  phasemean_multi #(.N_CH(N_CH), .W(W), .KMAX(KMAX), .WRAP_MODE(1)) u_wrap (
    .clock(clock), .reset(reset), .clear(clear), .enable(enable), .K(k),
    .in_sampl(in_sampl), .phaseout(phase_o[0]), .out_valid(valid_o[0]),
    .busy(busy_o[0]), .sample_cnt(cnt_o[0])
  );

  phasemean_multi #(.N_CH(N_CH), .W(W), .KMAX(KMAX), .WRAP_MODE(0)) u_plain (
    .clock(clock), .reset(reset), .clear(clear), .enable(enable), .K(k),
    .in_sampl(in_sampl), .phaseout(phase_o[1]), .out_valid(valid_o[1]),
    .busy(busy_o[1]), .sample_cnt(cnt_o[1])
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q [2][$];

  // Reference model state
  bit          m_open;
  int          m_kw, m_cnt;
  longint      m_ref [N_CH];
  longint      m_sum [2][N_CH];
  longint      cur   [N_CH];
  logic [PW-1:0] last_exp [2];

  function automatic longint wrapw(longint v);
    longint m = longint'(1) << W;
    longint r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  function automatic longint fdiv(longint a, longint n);
    longint r = a / n;
    if ((a % n != 0) && (a < 0)) r--;
    return r;
  endfunction

  function automatic longint chan(logic [PW-1:0] v, int c);
    logic [W-1:0] s = v[c*W +: W];
    return longint'($signed(s));
  endfunction

  task automatic check(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_vec(string name, logic [PW-1:0] act, logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_update(bit en, bit clr, int kin);
    longint n, v, mw, mp;
    logic [PW-1:0] ev [2];
    if (clr) begin
      m_open = 1'b0;
    end else if (en) begin
      if (!m_open) begin
        m_open = 1'b1;
        m_kw   = (kin > int'(KMAX)) ? int'(KMAX) : kin;
        m_cnt  = 0;
        for (int c = 0; c < N_CH; c++) begin
          m_ref[c] = wrapw(cur[c]);
          m_sum[0][c] = 0;
          m_sum[1][c] = 0;
        end
      end
      for (int c = 0; c < N_CH; c++) begin
        v = wrapw(cur[c]);
        m_sum[0][c] += wrapw(v - m_ref[c]);
        m_sum[1][c] += v;
      end
      m_cnt++;
      n = longint'(1) << m_kw;
      if (m_cnt == n) begin
        for (int c = 0; c < N_CH; c++) begin
          mw = wrapw(m_ref[c] + fdiv(m_sum[0][c] + n / 2, n));
          mp = fdiv(m_sum[1][c] + n / 2, n);
          ev[0][c*W +: W] = mw[W-1:0];
          ev[1][c*W +: W] = mp[W-1:0];
        end
        for (int i = 0; i < 2; i++) begin
          q[i].push_back('{v: ev[i], c: cyc + 1});
          last_exp[i] = ev[i];
        end
        m_open = 1'b0;
      end
    end
  endtask

  task automatic step(bit en, bit clr, int kin);
    enable = en;
    clear  = clr;
    k      = KW'(kin);
    for (int c = 0; c < N_CH; c++) in_sampl[c*W +: W] = cur[c][W-1:0];
    @(posedge clock);
    #1;
    model_update(en, clr, kin);
    enable = 1'b0;
    clear  = 1'b0;
  endtask

  task automatic rand_cur();
    for (int c = 0; c < N_CH; c++) cur[c] = longint'($urandom_range(0, 65535)) - 32768;
  endtask

  task automatic set_all(longint v);
    for (int c = 0; c < N_CH; c++) cur[c] = v;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
  endtask

  task automatic check_reset_state(string tag);
    for (int i = 0; i < 2; i++) begin
      check_vec({tag, "_phase"}, phase_o[i], '0);
      check({tag, "_valid"}, longint'(valid_o[i]), 0);
      check({tag, "_busy"}, longint'(busy_o[i]), 0);
      check({tag, "_cnt"}, longint'(cnt_o[i]), 0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_reset_state("async_reset");
    for (int i = 0; i < 2; i++) begin
      q[i].delete();
      last_exp[i] = '0;
    end
    m_open = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic mon(int i);
    exp_t e;
    if (valid_o[i]) begin
      if (q[i].size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = q[i].pop_front();
        check(i == 0 ? "valid_cycle_wrap" : "valid_cycle_plain", longint'(cyc), longint'(e.c));
        check_vec(i == 0 ? "phaseout_wrap" : "phaseout_plain", phase_o[i], e.v);
      end
    end else if (q[i].size() > 0 && q[i][0].c < cyc) begin
      e = q[i].pop_front();
      check(i == 0 ? "missed_valid_wrap" : "missed_valid_plain", 0, 1);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    reset = 1'b0; clear = 1'b0; enable = 1'b0; k = '0; in_sampl = '0;
    m_open = 1'b0; last_exp[0] = '0; last_exp[1] = '0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_state("reset");
    reset = 1'b1;

    // T1/T2: alternating 1000/2000 on channel 1, K=3.
    for (int i = 0; i < 8; i++) begin
      rand_cur();
      cur[1] = (i % 2 == 0) ? 1000 : 2000;
      step(1'b1, 1'b0, 3);
      if (i == 3) begin
        check("busy_mid_window", longint'(busy_o[0]), 1);
        check("cnt_mid_window", longint'(cnt_o[1]), 4);
      end
    end
    idle(2);
    check("t1_plain_ch1", chan(phase_o[1], 1), 1500);
    check("t2_wrap_ch1", chan(phase_o[0], 1), 1500);

    // T3: K=1 straddling +/-pi; clear lands in DONE and must not suppress out_valid.
    rand_cur(); cur[1] = 32000;  step(1'b1, 1'b0, 1);
    rand_cur(); cur[1] = -32000; step(1'b1, 1'b0, 1);
    step(1'b0, 1'b1, 1);
    idle(2);
    check("t3_wrap_ch1", chan(phase_o[0], 1), -32768);
    check("t3_plain_ch1", chan(phase_o[1], 1), 0);

    // T4: K=0, back-to-back single-sample windows.
    set_all(5);  step(1'b1, 1'b0, 0);
    set_all(-7); step(1'b1, 1'b0, 0);
    set_all(9);  step(1'b1, 1'b0, 0);
    idle(2);
    check("t4_last_plain", chan(phase_o[1], 4), 9);

    // T5: abort after 5 samples, then a K=2 window of constants.
    for (int i = 0; i < 5; i++) begin rand_cur(); step(1'b1, 1'b0, 3); end
    step(1'b0, 1'b1, 3);
    check("t5_busy_after_clear", longint'(busy_o[0]), 0);
    check("t5_cnt_after_clear", longint'(cnt_o[0]), 0);
    check_vec("t5_phase_held", phase_o[0], last_exp[0]);
    rand_cur(); step(1'b1, 1'b1, 2);
    check("clear_beats_enable_cnt", longint'(cnt_o[1]), 0);
    set_all(-5985);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2);
    idle(2);
    check("t5_wrap_ch0", chan(phase_o[0], 0), -5985);
    check("t5_plain_ch5", chan(phase_o[1], 5), -5985);

    // T6: reset mid-window, then a fresh window.
    for (int i = 0; i < 4; i++) begin rand_cur(); step(1'b1, 1'b0, 3); end
    do_reset();
    for (int i = 0; i < 8; i++) begin rand_cur(); step(1'b1, 1'b0, 3); end
    idle(2);

    // Clamp: K above KMAX gives a 2^KMAX window.
    for (int i = 0; i < (1 << KMAX); i++) begin rand_cur(); step(1'b1, 1'b0, 15); end
    idle(2);

    // Random traffic: gaps, stray clears, K changing mid-window.
    for (int i = 0; i < 1500; i++) begin
      rand_cur();
      step($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 2, $urandom_range(0, 5));
    end
    idle(3);
    check("scoreboard_drained_wrap", longint'(q[0].size()), 0);
    check("scoreboard_drained_plain", longint'(q[1].size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
